// File: rtl/spi_bus_arbiter_if.sv
// Bundle of the arbiter's client-side and shared-bus signals.
// The arbiter binds to the slave modport; the agent driving the requests binds to master.
interface spi_bus_arbiter_if;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       c0_spi_clk;
  logic       c0_spi_mosi;
  logic       c0_spi_ncs;
  logic       c1_spi_clk;
  logic       c1_spi_mosi;
  logic       c1_spi_ncs;
  logic       spi_clk;
  logic       spi_mosi;
  logic       lcd_cs_n;
  logic       flash_cs_n;
  logic       busy;
  logic       timeout_err;

  modport master (
    output req, c0_spi_clk, c0_spi_mosi, c0_spi_ncs,
           c1_spi_clk, c1_spi_mosi, c1_spi_ncs,
    input  gnt, spi_clk, spi_mosi, lcd_cs_n, flash_cs_n, busy, timeout_err
  );

  modport slave (
    input  req, c0_spi_clk, c0_spi_mosi, c0_spi_ncs,
           c1_spi_clk, c1_spi_mosi, c1_spi_ncs,
    output gnt, spi_clk, spi_mosi, lcd_cs_n, flash_cs_n, busy, timeout_err
  );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Two-client SPI bus arbiter (LCD = client 0, flash = client 1) with round-robin ties
// and an enforced idle gap. Optional grant hold timeout: define SPI_BUS_ARBITER_TIMEOUT_EN.
module spi_bus_arbiter #(
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT0, S_GRANT1, S_GAP} state_t;

  localparam int unsigned      GAP_W       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam state_t           AFTER_GRANT = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

  state_t           r_state;
  state_t           w_next;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_last_owner;
  logic [1:0]       r_gnt;
  logic [1:0]       w_elig;
  logic             w_timeout;
  logic             w_in_grant;

  logic w_spi_clk;
  logic w_spi_mosi;
  logic w_lcd_cs_n;
  logic w_flash_cs_n;

  assign w_in_grant = (r_state == S_GRANT0) || (r_state == S_GRANT1);

`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
  localparam int unsigned       HOLD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [HOLD_W-1:0] r_hold_cnt;
  logic [1:0]        r_block;
  logic              r_timeout_err;

  // A revoked client stays blocked until it has been seen with req low.
  assign w_elig    = bus.req & ~r_block;
  assign w_timeout = (r_hold_cnt == HOLD_LAST) &&
                     (((r_state == S_GRANT0) && bus.req[0]) ||
                      ((r_state == S_GRANT1) && bus.req[1]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt    <= '0;
      r_block       <= 2'b00;
      r_timeout_err <= 1'b0;
    end else begin
      r_hold_cnt    <= (w_in_grant && (w_next == r_state)) ? r_hold_cnt + 1'b1 : '0;
      r_timeout_err <= w_timeout;
      if (w_timeout && (r_state == S_GRANT0)) r_block[0] <= 1'b1;
      else if (!bus.req[0])                   r_block[0] <= 1'b0;
      if (w_timeout && (r_state == S_GRANT1)) r_block[1] <= 1'b1;
      else if (!bus.req[1])                   r_block[1] <= 1'b0;
    end
  end

  assign bus.timeout_err = r_timeout_err;
`else
  assign w_elig          = bus.req;
  assign w_timeout       = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_elig == 2'b11) w_next = r_last_owner ? S_GRANT0 : S_GRANT1;
        else if (w_elig[0])  w_next = S_GRANT0;
        else if (w_elig[1])  w_next = S_GRANT1;
      end
      S_GRANT0: if (!bus.req[0] || w_timeout) w_next = AFTER_GRANT;
      S_GRANT1: if (!bus.req[1] || w_timeout) w_next = AFTER_GRANT;
      S_GAP:    if (r_gap_cnt == GAP_LAST)   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap_cnt    <= '0;
      r_last_owner <= 1'b1;
      r_gnt        <= 2'b00;
    end else begin
      r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + 1'b1 : '0;
      if (r_state == S_IDLE && w_next == S_GRANT0) r_last_owner <= 1'b0;
      if (r_state == S_IDLE && w_next == S_GRANT1) r_last_owner <= 1'b1;
      r_gnt <= {w_next == S_GRANT1, w_next == S_GRANT0};
    end
  end

  // Bus pins decode from the state register only, so reset or leaving a grant
  // parks the selects high without waiting on any client input.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    w_spi_clk    = 1'b0;
    w_spi_mosi   = 1'b0;
    w_lcd_cs_n   = 1'b1;
    w_flash_cs_n = 1'b1;
    unique case (r_state)
      S_GRANT0: begin
        w_spi_clk  = bus.c0_spi_clk;
        w_spi_mosi = bus.c0_spi_mosi;
        w_lcd_cs_n = bus.c0_spi_ncs;
      end
      S_GRANT1: begin
        w_spi_clk    = bus.c1_spi_clk;
        w_spi_mosi   = bus.c1_spi_mosi;
        w_flash_cs_n = bus.c1_spi_ncs;
      end
      default: ;
    endcase
  end

  assign bus.spi_clk    = w_spi_clk;
  assign bus.spi_mosi   = w_spi_mosi;
  assign bus.lcd_cs_n   = w_lcd_cs_n;
  assign bus.flash_cs_n = w_flash_cs_n;
  assign bus.gnt        = r_gnt;
  assign bus.busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: instance A (GAP_CYCLES=4) and instance B (GAP_CYCLES=0),
// both with TIMEOUT_CYCLES=8; timeout checks follow SPI_BUS_ARBITER_TIMEOUT_EN.
module tb_spi_bus_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  spi_bus_arbiter_if a_if ();
  spi_bus_arbiter_if b_if ();

  spi_bus_arbiter #(.GAP_CYCLES(4), .TIMEOUT_CYCLES(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if)
  );

  spi_bus_arbiter #(.GAP_CYCLES(0), .TIMEOUT_CYCLES(8)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // {spi_clk, spi_mosi, lcd_cs_n, flash_cs_n}
  function automatic logic [3:0] pins_a();
    return {a_if.spi_clk, a_if.spi_mosi, a_if.lcd_cs_n, a_if.flash_cs_n};
  endfunction
  function automatic logic [3:0] pins_b();
    return {b_if.spi_clk, b_if.spi_mosi, b_if.lcd_cs_n, b_if.flash_cs_n};
  endfunction
  // {gnt[1:0], busy, timeout_err}
  function automatic logic [3:0] st_a();
    return {a_if.gnt, a_if.busy, a_if.timeout_err};
  endfunction
  function automatic logic [3:0] st_b();
    return {b_if.gnt, b_if.busy, b_if.timeout_err};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_clients();
    a_if.c0_spi_clk = 1'b0; a_if.c0_spi_mosi = 1'b0; a_if.c0_spi_ncs = 1'b1;
    a_if.c1_spi_clk = 1'b0; a_if.c1_spi_mosi = 1'b0; a_if.c1_spi_ncs = 1'b1;
    b_if.c0_spi_clk = 1'b0; b_if.c0_spi_mosi = 1'b0; b_if.c0_spi_ncs = 1'b1;
    b_if.c1_spi_clk = 1'b0; b_if.c1_spi_mosi = 1'b0; b_if.c1_spi_ncs = 1'b1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    a_if.req  = 2'b00;
    b_if.req  = 2'b00;
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    a_if.req = 2'b00;
    b_if.req = 2'b00;
    idle_clients();

    // Reset state, with client 0 inputs active to prove they do not leak.
    #12;
    a_if.c0_spi_clk = 1'b1; a_if.c0_spi_mosi = 1'b1; a_if.c0_spi_ncs = 1'b0;
    settle();
    check("rst_pins", pins_a(), 4'b0011);
    check("rst_state", st_a(), 4'b0000);
    check("rst_state_b", st_b(), 4'b0000);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    check("idle_pins_ignore_inputs", pins_a(), 4'b0011);

    // Single request: grant one cycle later, lcd_cs_n follows client 0.
    idle_clients();
    a_if.req = 2'b01;
    settle();
    check("pre_gnt", st_a(), 4'b0000);
    tick();
    check("gnt0", st_a(), 4'b0110);
    a_if.c0_spi_clk = 1'b1; a_if.c0_spi_mosi = 1'b1; a_if.c0_spi_ncs = 1'b0;
    a_if.c1_spi_ncs = 1'b0;
    settle();
    check("g0_follow", pins_a(), 4'b1101);
    a_if.c0_spi_clk = 1'b0; a_if.c0_spi_mosi = 1'b0;
    a_if.c1_spi_clk = 1'b1; a_if.c1_spi_mosi = 1'b1;
    settle();
    check("g0_isolate_c1", pins_a(), 4'b0001);

    // Client 0 drops req with ncs still low: select forced high on the leaving edge.
    a_if.req = 2'b00;
    tick();
    check("drop_cs_forced", pins_a(), 4'b0011);
    check("drop_gap", st_a(), 4'b0010);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("gap_hold", st_a(), 4'b0010);
    end
    tick();
    check("gap_end_idle", st_a(), 4'b0000);
    idle_clients();

    // Tie after reset: client 0 first, then client 1 after 4 gap cycles and one idle cycle.
    do_reset();
    a_if.req = 2'b11;
    tick();
    check("tie_first_c0", st_a(), 4'b0110);
    tick();
    check("tie_hold", st_a(), 4'b0110);
    a_if.req = 2'b10;
    tick();
    check("tie_gap", st_a(), 4'b0010);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("tie_gap_cs", pins_a(), 4'b0011);
    end
    tick();
    check("tie_idle_between", st_a(), 4'b0000);
    tick();
    check("gnt1_after_gap", st_a(), 4'b1010);
    a_if.c1_spi_ncs = 1'b0; a_if.c1_spi_clk = 1'b1; a_if.c1_spi_mosi = 1'b0;
    a_if.c0_spi_ncs = 1'b0; a_if.c0_spi_clk = 1'b0; a_if.c0_spi_mosi = 1'b1;
    settle();
    check("g1_follow", pins_a(), 4'b1010);

    // Asynchronous reset during GRANT1 with c1 ncs low, checked before any edge.
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_pins", pins_a(), 4'b0011);
    check("async_rst_state", st_a(), 4'b0000);
    a_if.req = 2'b00;
    idle_clients();
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // Round-robin: client 0 releases while client 1 waits, re-requests during GAP.
    a_if.req = 2'b01;
    tick();
    check("rr_g0", st_a(), 4'b0110);
    a_if.req = 2'b11;
    tick();
    a_if.req = 2'b10;
    tick();
    check("rr_gap", st_a(), 4'b0010);
    a_if.req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rr_gap_holdoff", st_a(), 4'b0010);
    end
    tick();
    check("rr_idle", st_a(), 4'b0000);
    tick();
    check("rr_c1", st_a(), 4'b1010);
    a_if.req = 2'b00;
    repeat (5) tick();
    check("rr_release", st_a(), 4'b0000);

    // GAP_CYCLES=0: back-to-back grants separated by exactly one idle cycle.
    b_if.req = 2'b01;
    tick();
    check("b_g0", st_b(), 4'b0110);
    b_if.c0_spi_ncs = 1'b0;
    b_if.c1_spi_ncs = 1'b0;
    b_if.req = 2'b10;
    settle();
    check("b_g0_pins", pins_b(), 4'b0001);
    tick();
    check("b_idle_one", st_b(), 4'b0000);
    check("b_idle_pins", pins_b(), 4'b0011);
    tick();
    check("b_g1", st_b(), 4'b1010);
    check("b_g1_pins", pins_b(), 4'b0010);
    b_if.req = 2'b00;
    idle_clients();
    tick();
    check("b_release", st_b(), 4'b0000);

`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
    // Hold limit of 8 cycles, one-cycle error pulse, no re-grant until req toggles low.
    a_if.req = 2'b01;
    tick();
    check("to_g0", st_a(), 4'b0110);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("to_hold", st_a(), 4'b0110);
    end
    tick();
    check("to_revoke", st_a(), 4'b0011);
    tick();
    check("to_pulse_once", st_a(), 4'b0010);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("to_blocked", {a_if.gnt, 1'b0, a_if.timeout_err}, 4'b0000);
    end
    a_if.req = 2'b00;
    tick();
    a_if.req = 2'b01;
    tick();
    check("to_regrant", st_a(), 4'b0110);
    a_if.req = 2'b00;
`else
    // No timeout built: the grant is held indefinitely and timeout_err stays 0.
    a_if.req = 2'b01;
    tick();
    for (int i = 0; i < 12; i++) begin
      tick();
      check("no_to_hold", st_a(), 4'b0110);
    end
    a_if.req = 2'b00;
`endif
    repeat (6) tick();
    check("final_idle", st_a(), 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
